// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared definitions for the AHB bus arbiter: transfer encodings, arbiter
// states and a width helper.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic {
      PARK = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         r = ((32'd1 << i) < value) ? i + 1 : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin scan: first candidate at or after ptr, wrapping,
// with an optional exclusion mask.
module rr_picker
   import ahb_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic [N-1:0]  exclude,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [N-1:0] cand_s;

   assign cand_s = req & ~exclude;

   // Each index is visited exactly once, so winner bits can be written directly.
   always_comb begin
      int            sum;
      logic [PW-1:0] idx;
      logic          hit;
      winner = '0;
      valid  = 1'b0;
      sum    = 0;
      idx    = '0;
      hit    = 1'b0;
      for (int k = 0; k < N; k++) begin
         sum         = int'(ptr) + k;
         sum         = (sum >= N) ? sum - N : sum;
         idx         = PW'(sum);
         hit         = !valid && cand_s[idx];
         winner[idx] = hit;
         valid       = valid | hit;
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with tenure cap, sharing one bridge slave port.
// Optional bus locking is built when ARB_HLOCK_EN is defined.
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_M     = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BEATS = 8,
   localparam int MW       = clog2(NUM_M)
) (
   input  logic                hclk,
   input  logic                hreset,
   input  logic [NUM_M-1:0]    hbusreq,
   input  logic [NUM_M*AW-1:0] haddr_m,
   input  logic [NUM_M*2-1:0]  htrans_m,
   input  logic [NUM_M-1:0]    hwrite_m,
   input  logic [NUM_M*DW-1:0] hwdata_m,
`ifdef ARB_HLOCK_EN
   input  logic [NUM_M-1:0]    hlock,
`endif
   input  logic                hreadyout,
   output logic [NUM_M-1:0]    hgrant,
   output logic [MW-1:0]       hmaster,
   output logic [MW-1:0]       hmaster_d,
   output logic [AW-1:0]       haddr,
   output logic [1:0]          htrans,
   output logic                hwrite,
   output logic [DW-1:0]       hwdata,
   output logic                hreadyin
);

   localparam logic [NUM_M-1:0] DEFAULT_GRANT = {{(NUM_M-1){1'b0}}, 1'b1};

   arb_state_e       state_r;
   logic [7:0]       count_r;
   logic [MW-1:0]    ptr_r;
   logic [NUM_M-1:0] hgrant_r;
   logic [MW-1:0]    hmaster_r;
   logic [MW-1:0]    hmaster_d_r;

   logic             owner_req_s, others_s, cap_s, locked_s, accept_s;
   logic             rearb_s, regrant_s, changed_s;
   logic [NUM_M-1:0] exclude_s, win_oh_s;
   logic             win_valid_s;
   logic [MW-1:0]    win_idx_s, next_ptr_s, new_master_s;
   logic [7:0]       count_next_s;

   assign hgrant    = hgrant_r;
   assign hmaster   = hmaster_r;
   assign hmaster_d = hmaster_d_r;

   assign haddr    = haddr_m[int'(hmaster_r)*AW +: AW];
   assign htrans   = htrans_m[int'(hmaster_r)*2 +: 2];
   assign hwrite   = hwrite_m[hmaster_r];
   assign hwdata   = hwdata_m[int'(hmaster_d_r)*DW +: DW];
   assign hreadyin = hreadyout;

   // hgrant_r is always the one-hot form of hmaster_r, so it doubles as the owner mask.
   assign owner_req_s = |(hbusreq & hgrant_r);
   assign others_s    = |(hbusreq & ~hgrant_r);
   assign cap_s       = (count_r >= 8'(MAX_BEATS));

`ifdef ARB_HLOCK_EN
   assign locked_s = |(hlock & hgrant_r);
`else
   assign locked_s = 1'b0;
`endif

   assign rearb_s   = !locked_s &&
                      (!owner_req_s || (cap_s && others_s) ||
                       ((state_r == PARK) && (|hbusreq)));
   assign regrant_s = !locked_s && (state_r == OWN) && cap_s && owner_req_s && !others_s;
   assign exclude_s = ((state_r == OWN) && cap_s && owner_req_s) ? hgrant_r : '0;

   rr_picker #(
      .N  (NUM_M),
      .PW (MW)
   ) u_picker (
      .req     (hbusreq),
      .ptr     (ptr_r),
      .exclude (exclude_s),
      .winner  (win_oh_s),
      .valid   (win_valid_s)
   );

   // Encode the one-hot winner into a master index.
   always_comb begin
      win_idx_s = '0;
      for (int i = 0; i < NUM_M; i++) begin
         win_idx_s = win_idx_s | (win_oh_s[i] ? MW'(i) : '0);
      end
   end

   assign next_ptr_s   = (win_idx_s == MW'(NUM_M - 1)) ? '0 : win_idx_s + MW'(1);
   assign new_master_s = win_valid_s ? win_idx_s : '0;
   assign changed_s    = rearb_s && (new_master_s != hmaster_r);

   // Only NONSEQ/SEQ address phases count toward the tenure.
   always_comb begin
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: accept_s = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  accept_s = 1'b0;
         default:                   accept_s = 1'b0;
      endcase
   end

   // Tenure counter next value: clears on owner change or solo re-grant, saturates at the cap.
   always_comb begin
      if (changed_s || regrant_s) begin
         count_next_s = 8'd0;
      end else if (accept_s && !cap_s) begin
         count_next_s = count_r + 8'd1;
      end else begin
         count_next_s = count_r;
      end
   end

   // Arbitration FSM; every update waits for the bridge to accept the current phase.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_r     <= PARK;
         hgrant_r    <= DEFAULT_GRANT;
         hmaster_r   <= '0;
         hmaster_d_r <= '0;
         ptr_r       <= MW'(1);
         count_r     <= 8'd0;
      end else if (hreadyout) begin
         hmaster_d_r <= hmaster_r;
         count_r     <= count_next_s;
         if (rearb_s) begin
            state_r   <= win_valid_s ? OWN : PARK;
            hgrant_r  <= win_valid_s ? win_oh_s : DEFAULT_GRANT;
            hmaster_r <= new_master_s;
            ptr_r     <= win_valid_s ? next_ptr_s : ptr_r;
         end else begin
            state_r   <= state_r;
            hgrant_r  <= hgrant_r;
            hmaster_r <= hmaster_r;
            ptr_r     <= ptr_r;
         end
      end else begin
         state_r     <= state_r;
         hgrant_r    <= hgrant_r;
         hmaster_r   <= hmaster_r;
         hmaster_d_r <= hmaster_d_r;
         ptr_r       <= ptr_r;
         count_r     <= count_r;
      end
   end

endmodule
